// File: rtl/line_scanout.sv
// Line-cache read side: fetches a packed pixel line from the BRAM byte port
// and shifts it out MSB-first as PIX_W-bit pixels paced by pix_en.
module line_scanout #(
    parameter int ADDR_W     = 8,
    parameter int LINE_BYTES = 40,
    parameter int PIX_W      = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] line_base,
    input  logic              pix_en,
    output logic              ram_ce,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [PIX_W-1:0]  pixel,
    output logic              busy,
    output logic              done,
    output logic              underrun
);
    localparam int PPB  = 8 / PIX_W;
    localparam int NPIX = LINE_BYTES * PPB;
    localparam int BI_W = $clog2(LINE_BYTES + 1);
    localparam int PC_W = $clog2(NPIX + 1);
    localparam int SC_W = $clog2(PPB);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_addr;
    logic [BI_W-1:0]   bytes_issued;
    logic [PC_W-1:0]   pix_cnt;
    logic [RD_LAT-1:0] vpipe;
    logic [7:0]        shifter;
    logic [7:0]        next_byte;
    logic [SC_W-1:0]   shift_cnt;
    logic              sh_valid;
    logic              next_valid;

    logic arrive;
    logic in_flight;
    logic issue;
    logic pix_tick;
    logic consume;
    logic last_pix;
    logic sh_empty_nxt;
    logic line_end;

    always_comb begin
        arrive       = vpipe[RD_LAT-1];
        in_flight    = ram_ce | (|vpipe);
        pix_tick     = (state != IDLE) && pix_en;
        consume      = (state == RUN) && pix_en && sh_valid;
        last_pix     = consume && (shift_cnt == SC_W'(PPB - 1));
        sh_empty_nxt = !sh_valid || (last_pix && !next_valid);
        line_end     = pix_tick && (pix_cnt == PC_W'(NPIX - 1));
        issue        = 1'b0;
        if (state == PRIME)
            issue = (bytes_issued == BI_W'(1)) && (LINE_BYTES > 1);
        else if (state == RUN)
            issue = !next_valid && !in_flight &&
                    (bytes_issued < BI_W'(LINE_BYTES));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            ram_ce       <= 1'b0;
            ram_addr     <= '0;
            pixel        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
            fetch_addr   <= '0;
            bytes_issued <= '0;
            pix_cnt      <= '0;
            vpipe        <= '0;
            shifter      <= '0;
            next_byte    <= '0;
            shift_cnt    <= '0;
            sh_valid     <= 1'b0;
            next_valid   <= 1'b0;
        end else begin
            done   <= 1'b0;
            ram_ce <= 1'b0;
            if (line_start) begin
                // abort anything in progress; stale reads die with vpipe
                state        <= PRIME;
                busy         <= 1'b1;
                underrun     <= 1'b0;
                pixel        <= '0;
                ram_ce       <= 1'b1;
                ram_addr     <= line_base;
                fetch_addr   <= line_base + 1'b1;
                bytes_issued <= BI_W'(1);
                pix_cnt      <= '0;
                vpipe        <= '0;
                shifter      <= '0;
                next_byte    <= '0;
                shift_cnt    <= '0;
                sh_valid     <= 1'b0;
                next_valid   <= 1'b0;
            end else if (state == IDLE) begin
                pixel <= '0;
            end else begin
                vpipe <= RD_LAT'({vpipe, ram_ce});
                if (issue) begin
                    ram_ce       <= 1'b1;
                    ram_addr     <= fetch_addr;
                    fetch_addr   <= fetch_addr + 1'b1;
                    bytes_issued <= bytes_issued + 1'b1;
                end
                if (pix_tick) begin
                    pix_cnt <= pix_cnt + 1'b1;
                    if (consume) begin
                        pixel <= shifter[7 -: PIX_W];
                    end else begin
                        pixel    <= '0;
                        underrun <= 1'b1;
                    end
                end
                if (last_pix) begin
                    shift_cnt <= '0;
                    if (next_valid) begin
                        shifter    <= next_byte;
                        next_valid <= 1'b0;
                    end else begin
                        sh_valid <= 1'b0;
                    end
                end else if (consume) begin
                    shifter   <= shifter << PIX_W;
                    shift_cnt <= shift_cnt + 1'b1;
                end
                // data landing on an empty shifter waits for the next strobe
                if (arrive) begin
                    if (sh_empty_nxt) begin
                        shifter   <= ram_dout;
                        sh_valid  <= 1'b1;
                        shift_cnt <= '0;
                    end else begin
                        next_byte  <= ram_dout;
                        next_valid <= 1'b1;
                    end
                end
                if (state == PRIME && arrive)
                    state <= RUN;
                if (line_end) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    vpipe <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_scanout.sv
// Scoreboard bench for line_scanout: a 4-bit/2-byte instance and a
// 1-bit/40-byte instance, each fed from a shared BRAM model.
module tb_line_scanout;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];

    logic       a_ls, a_pe, a_ce, a_busy, a_done, a_ur;
    logic [7:0] a_base, a_addr;
    logic [7:0] a_r1 = 8'h00;
    logic [7:0] a_dout = 8'h00;
    logic [3:0] a_pix;

    logic       b_ls, b_pe, b_ce, b_busy, b_done, b_ur;
    logic [7:0] b_base, b_addr;
    logic [7:0] b_r1 = 8'h00;
    logic [7:0] b_dout = 8'h00;
    logic [0:0] b_pix;

    line_scanout #(
        .ADDR_W(8), .LINE_BYTES(2), .PIX_W(4), .RD_LAT(2)
    ) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .line_start(a_ls), .line_base(a_base), .pix_en(a_pe),
        .ram_ce(a_ce), .ram_addr(a_addr), .ram_dout(a_dout),
        .pixel(a_pix), .busy(a_busy), .done(a_done), .underrun(a_ur)
    );

    line_scanout #(
        .ADDR_W(8), .LINE_BYTES(40), .PIX_W(1), .RD_LAT(2)
    ) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .line_start(b_ls), .line_base(b_base), .pix_en(b_pe),
        .ram_ce(b_ce), .ram_addr(b_addr), .ram_dout(b_dout),
        .pixel(b_pix), .busy(b_busy), .done(b_done), .underrun(b_ur)
    );

    // two-cycle registered-output BRAM
    always @(posedge clk) begin
        if (a_ce) a_r1 <= mem[a_addr];
        a_dout <= a_r1;
        if (b_ce) b_r1 <= mem[b_addr];
        b_dout <= b_r1;
    end

    int n_chk = 0;
    int n_err = 0;
    int a_dn = 0;
    int b_dn = 0;
    logic a_pv = 1'b0;
    logic b_pv = 1'b0;
    logic [4:0] a_q[$];
    logic [1:0] b_q[$];
    logic [7:0] a_rd[$];
    logic [7:0] b_rd[$];
    logic [4:0] ea;
    logic [1:0] eb;

    always @(posedge clk) begin
        a_pv <= a_pe;
        b_pv <= b_pe;
    end

    always @(negedge clk) begin
        if (a_ce) a_rd.push_back(a_addr);
        if (b_ce) b_rd.push_back(b_addr);
        if (a_done) a_dn++;
        if (b_done) b_dn++;
        if (a_pv) begin
            n_chk++;
            if (a_q.size() == 0) begin
                n_err++;
                $display("FAIL a_pix: unexpected pixel %h", a_pix);
            end else begin
                ea = a_q.pop_front();
                if ({a_ur, a_pix} !== ea) begin
                    n_err++;
                    $display("FAIL a_pix: got ur=%b pix=%h, expected ur=%b pix=%h",
                             a_ur, a_pix, ea[4], ea[3:0]);
                end
            end
        end
        if (b_pv) begin
            n_chk++;
            if (b_q.size() == 0) begin
                n_err++;
                $display("FAIL b_pix: unexpected pixel %b", b_pix);
            end else begin
                eb = b_q.pop_front();
                if ({b_ur, b_pix} !== eb) begin
                    n_err++;
                    $display("FAIL b_pix: got ur=%b pix=%b, expected ur=%b pix=%b",
                             b_ur, b_pix, eb[1], eb[0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [7:0] q[$], input int i);
        return (q.size() > i) ? 32'(q[i]) : 32'hDEAD;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pa(input logic ur, input logic [3:0] p);
        a_q.push_back({ur, p});
    endtask

    // drive one instance for ncyc cycles; pix_en on cycles f..f+n-1
    task automatic drive(input bit sel, input bit ls, input logic [7:0] base,
                         input int f, input int n, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (!sel) begin
                a_ls   = ls && (c == 0);
                a_base = base;
                a_pe   = (c >= f) && (c < f + n);
            end else begin
                b_ls   = ls && (c == 0);
                b_base = base;
                b_pe   = (c >= f) && (c < f + n);
            end
            tick();
        end
        a_ls = 1'b0; a_pe = 1'b0;
        b_ls = 1'b0; b_pe = 1'b0;
    endtask

    task automatic clr();
        a_dn = 0;
        b_dn = 0;
        a_rd.delete();
        b_rd.delete();
    endtask

    int hv[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [7:0] bb;

    initial begin
        a_ls = 1'b0; a_pe = 1'b0; a_base = 8'h00;
        b_ls = 1'b0; b_pe = 1'b0; b_base = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 29 + 7);
        mem[8'h80] = 8'h5A; mem[8'h81] = 8'hC3;
        mem[8'h40] = 8'h12; mem[8'h41] = 8'h34;
        mem[8'h20] = 8'h9E; mem[8'h21] = 8'h7B;
        mem[8'hFF] = 8'hA5;

        repeat (3) tick();
        chk("reset_a", 32'({a_ce, a_addr, a_pix, a_busy, a_done, a_ur}), 0);
        chk("reset_b", 32'({b_ce, b_addr, b_pix, b_busy, b_done, b_ur}), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // strobe in the first PRIME cycle: zero pixel, sticky underrun
        clr();
        pa(1, 4'h0); pa(1, 4'h5); pa(1, 4'hA); pa(1, 4'hC);
        drive(0, 1, 8'h80, 1, 1, 2);
        drive(0, 0, 8'h00, 2, 3, 10);
        chk("ur_sticky", 32'(a_ur), 1);
        chk("ur_done", 32'(a_dn), 1);

        // nominal line; line_start clears underrun
        clr();
        pa(0, 4'h5); pa(0, 4'hA); pa(0, 4'hC); pa(0, 4'h3);
        drive(0, 1, 8'h80, 99, 0, 2);
        chk("busy_c1", 32'(a_busy), 1);
        chk("ur_clr", 32'(a_ur), 0);
        drive(0, 0, 8'h00, 2, 4, 10);
        chk("t1_done", 32'(a_dn), 1);
        chk("t1_nrd", 32'(a_rd.size()), 2);
        chk("t1_rd0", qat(a_rd, 0), 32'h80);
        chk("t1_rd1", qat(a_rd, 1), 32'h81);
        chk("t1_idle", 32'({a_pix, a_busy, a_ur}), 0);

        // restart after three pixels of the 0x40 line
        clr();
        pa(0, 4'h1); pa(0, 4'h2); pa(0, 4'h3);
        pa(0, 4'h9); pa(0, 4'hE); pa(0, 4'h7); pa(0, 4'hB);
        drive(0, 1, 8'h40, 4, 3, 7);
        drive(0, 1, 8'h20, 4, 4, 12);
        chk("mid_done", 32'(a_dn), 1);
        chk("mid_ur", 32'(a_ur), 0);
        chk("mid_nrd", 32'(a_rd.size()), 4);
        chk("mid_rd2", qat(a_rd, 2), 32'h20);
        chk("mid_rd3", qat(a_rd, 3), 32'h21);

        // restart while both reads are in flight
        clr();
        pa(0, 4'h9); pa(0, 4'hE); pa(0, 4'h7); pa(0, 4'hB);
        drive(0, 1, 8'h40, 99, 0, 2);
        drive(0, 1, 8'h20, 4, 4, 12);
        chk("fly_done", 32'(a_dn), 1);
        chk("fly_ur", 32'(a_ur), 0);
        chk("fly_nrd", 32'(a_rd.size()), 4);

        // async reset mid-RUN
        clr();
        pa(0, 4'h5);
        drive(0, 1, 8'h80, 4, 1, 6);
        chk("pre_rst_busy", 32'(a_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({a_ce, a_addr, a_pix, a_busy, a_done, a_ur}), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_nodone", 32'(a_dn), 0);

        // 320 1-bit pixels from base 0xFF, addresses wrap
        clr();
        for (int j = 0; j < 8; j++) b_q.push_back({1'b0, 1'(hv[j])});
        for (int k = 1; k < 40; k++) begin
            bb = mem[8'(8'hFF + k)];
            for (int j = 7; j >= 0; j--) b_q.push_back({1'b0, bb[j]});
        end
        drive(1, 1, 8'hFF, 4, 320, 330);
        chk("b_done", 32'(b_dn), 1);
        chk("b_ur", 32'(b_ur), 0);
        chk("b_nrd", 32'(b_rd.size()), 40);
        chk("b_rd0", qat(b_rd, 0), 32'hFF);
        chk("b_rd1", qat(b_rd, 1), 32'h00);
        chk("b_rd2", qat(b_rd, 2), 32'h01);
        chk("b_rd39", qat(b_rd, 39), 32'h26);
        chk("b_idle", 32'({b_pix, b_busy}), 0);

        chk("a_q_left", 32'(a_q.size()), 0);
        chk("b_q_left", 32'(b_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/line_scanout.md
Name: line_scanout

Overview:
- Read-side counterpart to the nibble/byte line-cache writers in the composite video path.
- On each line start, fetches a packed pixel line from the 8-bit port of the dual-port line BRAM and serializes it, MSB-first, into a PIX_W-bit pixel stream paced by the pixel-clock enable.
- Sits between the line cache BRAM (port A, read-only use) and the composite DAC encoder.
- Hides BRAM read latency with a one-byte prefetch.

Parameters:
- ADDR_W, 8, BRAM byte-port address width; addresses wrap modulo 2^ADDR_W.
- LINE_BYTES, 40, bytes per active line (1..2^ADDR_W).
- PIX_W, 4, bits per pixel; legal values 1, 2, 4; pixels per byte PPB = 8/PIX_W.
- RD_LAT, 2, BRAM read latency in cycles from ram_ce/ram_addr to valid ram_dout; legal values 1 (oce bypass) or 2 (output register).

Ports:
- sys_clk, input, 1, system clock; all logic rises on posedge.
- sys_rst_n, input, 1, asynchronous active-low reset.
- line_start, input, 1, one-cycle pulse: begin a new line.
- line_base, input, ADDR_W, byte address of the first byte; sampled on line_start.
- pix_en, input, 1, pixel strobe: consume one pixel this cycle.
- ram_ce, output, 1, BRAM port clock/output enable; high only in cycles issuing a read.
- ram_addr, output, ADDR_W, BRAM read address.
- ram_dout, input, 8, BRAM read data, valid RD_LAT cycles after the read.
- pixel, output, PIX_W, current pixel value.
- busy, output, 1, high from the cycle after line_start until done.
- done, output, 1, one-cycle pulse after the last pixel is consumed.
- underrun, output, 1, sticky error flag; cleared by line_start.

Behaviour:
- Reset (async, immediate): state IDLE; ram_ce=0, ram_addr=0, pixel=0, busy=0, done=0, underrun=0; shifter, next-byte, in-flight pipe, and counters cleared.
- States: IDLE, PRIME, RUN.
- IDLE:
  - Outputs idle; pix_en ignored; pixel holds 0.
  - line_start: latch line_base as the fetch address, clear underrun, go to PRIME.
- PRIME:
  - First cycle issues a read: ram_ce=1, ram_addr=base.
  - Data arrives RD_LAT cycles later and loads the shifter; go to RUN.
  - A second read (base+1) is issued the cycle after the first, if LINE_BYTES>1.
  - pix_en in PRIME: underrun=1, pixel=0; the pixel counter still advances.
- RUN:
  - pix_en: the registered pixel output (valid the cycle after pix_en) takes shifter[7:8-PIX_W]; shifter shifts left by PIX_W.
  - After the PPB-th pixel of a byte: next-byte loads into the shifter in the same edge and next_valid clears.
  - If next_valid=0 at that point: shifter is marked empty. Later pix_en while empty gives pixel=0 and underrun=1; the pixel counter still advances so line length is preserved.
  - Prefetch rule: issue a read (ram_ce=1 for one cycle, address+1 mod 2^ADDR_W) when next_valid=0, no read in flight, and bytes_issued < LINE_BYTES.
  - Returning data goes to next-byte, or directly to the shifter if the shifter is empty.
  - Data arriving in the same cycle as a pix_en on an empty shifter does not satisfy that pixel: it counts as underrun, and the data is kept for the next pixel.
- Line end: when LINE_BYTES*PPB pix_en strobes have been counted, done=1 for one cycle, busy=0, state IDLE, and pixel=0 on the following cycle.
- line_start while busy: abort and restart.
  - In-flight reads are discarded: the RD_LAT-deep valid pipe is cleared.
  - next_valid, the shifter, and counters are cleared.
  - Fetch restarts at the new line_base; no done pulse for the aborted line.
- line_start coincident with the final pix_en: restart takes priority; done is not pulsed.
- Counters: bytes_issued is ceil(log2(LINE_BYTES+1)) bits; the pixel counter is sized for LINE_BYTES*PPB; no overflow within a line.
- ram_ce is never high outside PRIME/RUN, and at most RD_LAT+1 reads are outstanding across a restart boundary (stale data is ignored).

Test Plan:
- Preload bytes 0x80=0x5A, 0x81=0xC3; LINE_BYTES=2, PIX_W=4, RD_LAT=2; line_start with base=0x80, then pix_en every cycle from the 4th cycle → pixel sequence 5,A,C,3; done pulses once after the 4th pixel; underrun=0; exactly 2 ram_ce cycles at addresses 0x80, 0x81.
- PIX_W=1, byte 0xA5, LINE_BYTES=1 → pixels 1,0,1,0,0,1,0,1; done after the 8th pix_en.
- pix_en on the cycle immediately after line_start (RD_LAT=2) → pixel=0, underrun=1 and sticky through line end; the next line_start clears it.
- base=0xFF, LINE_BYTES=3 → reads at 0xFF, 0x00, 0x01 (address wrap).
- Continuous pix_en, PIX_W=1, LINE_BYTES=40, RD_LAT=2 → 320 pixels matching memory, no underrun, never more than one prefetched byte pending.
- line_start at 0x20 mid-line (after 3 pixels from base 0x40), plus async sys_rst_n asserted mid-RUN → restart yields the 0x20 data with no stale 0x4x pixel and no done for the aborted line; reset drives all outputs to 0 immediately.
